// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types and field positions for the systolic instruction scheduler
package systolic_pkg;

  localparam int OPC_MSB  = 63;
  localparam int OPC_LSB  = 60;
  localparam int ADDR_MSB = 59;
  localparam int ADDR_LSB = 44;
  localparam int LEN_MSB  = 43;
  localparam int LEN_LSB  = 32;

  typedef enum logic [3:0] {
    OP_NOP    = 4'd0,
    OP_LOAD_W = 4'd1,
    OP_LOAD_A = 4'd2,
    OP_MATMUL = 4'd3,
    OP_STORE  = 4'd4,
    OP_HALT   = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    MEM_LOAD_W = 2'd0,
    MEM_LOAD_A = 2'd1,
    MEM_STORE  = 2'd2
  } mem_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_CLEAR,
    ST_COMPUTE,
    ST_HALT
  } sched_state_e;

  // opcode kept as raw bits so undefined encodings survive decoding
  typedef struct packed {
    logic [3:0]  opcode;
    logic [15:0] addr;
    logic [11:0] len;
    logic [31:0] rsvd;
  } instr_t;

  function automatic instr_t unpack_instr(input logic [63:0] w);
    instr_t r;
    r.opcode = w[OPC_MSB:OPC_LSB];
    r.addr   = w[ADDR_MSB:ADDR_LSB];
    r.len    = w[LEN_MSB:LEN_LSB];
    r.rsvd   = w[LEN_LSB-1:0];
    return r;
  endfunction

  function automatic mem_op_e to_mem_op(input logic [3:0] opc);
    case (opc)
      OP_LOAD_A: return MEM_LOAD_A;
      OP_STORE:  return MEM_STORE;
      default:   return MEM_LOAD_W;
    endcase
  endfunction

endpackage

// File: rtl/systolic_instr_scheduler_if.sv
// rtl/systolic_instr_scheduler_if.sv - instruction, memory-command and array-control signal bundle
interface systolic_instr_scheduler_if;
  logic        instr_valid;
  logic [63:0] instr_data;
  logic        instr_ready;
  logic        mem_cmd_valid;
  logic [1:0]  mem_cmd_op;
  logic [15:0] mem_cmd_addr;
  logic [11:0] mem_cmd_len;
  logic        mem_cmd_ready;
  logic        mem_done;
  logic        array_clear;
  logic        array_en;
  logic        busy;
  logic        halted;
  logic        illegal_instr;

  modport master (
    input  instr_valid, instr_data, mem_cmd_ready, mem_done,
    output instr_ready, mem_cmd_valid, mem_cmd_op, mem_cmd_addr, mem_cmd_len,
           array_clear, array_en, busy, halted, illegal_instr
  );

  modport slave (
    output instr_valid, instr_data, mem_cmd_ready, mem_done,
    input  instr_ready, mem_cmd_valid, mem_cmd_op, mem_cmd_addr, mem_cmd_len,
           array_clear, array_en, busy, halted, illegal_instr
  );
endinterface

// File: rtl/compute_timer.sv
// rtl/compute_timer.sv - loadable down-counter that times one array compute run
module compute_timer #(
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             active_o,
  output logic             last_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign active_o = (count_q != '0);
  assign last_o   = (count_q == CNT_W'(1));

endmodule

// File: rtl/systolic_instr_scheduler.sv
// rtl/systolic_instr_scheduler.sv - decodes buffered instructions into memory commands and timed array runs
module systolic_instr_scheduler
  import systolic_pkg::*;
#(
  parameter int ARRAY_SIZE = 8,
  parameter int CNT_W      = 14
) (
  input logic                       clk,
  input logic                       rst,
  systolic_instr_scheduler_if.master bus
);

  // wavefront takes 2*N-2 extra steps to drain through an N x N array
  localparam logic [CNT_W-1:0] PIPE_FILL = CNT_W'(2 * ARRAY_SIZE - 2);

  sched_state_e     state_q, state_d;
  instr_t           instr_q, instr_d, instr_in;
  logic             illegal_q, illegal_d;
  logic             timer_load, timer_dec, timer_active, timer_last;
  logic [CNT_W-1:0] timer_load_val;
  logic             instr_ready, cmd_valid, arr_clear, arr_en;
  mem_op_e          cmd_op;
  logic [15:0]      cmd_addr;
  logic [11:0]      cmd_len;
  logic             unused_rsvd;

  assign instr_in       = unpack_instr(bus.instr_data);
  assign timer_load_val = CNT_W'(instr_q.len) + PIPE_FILL;
  assign unused_rsvd    = ^instr_q.rsvd;

  compute_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (timer_load_val),
    .dec_i      (timer_dec),
    .active_o   (timer_active),
    .last_o     (timer_last)
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    illegal_d   = illegal_q;
    timer_load  = 1'b0;
    timer_dec   = 1'b0;
    instr_ready = 1'b0;
    cmd_valid   = 1'b0;
    cmd_op      = MEM_LOAD_W;
    cmd_addr    = '0;
    cmd_len     = '0;
    arr_clear   = 1'b0;
    arr_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (bus.instr_valid) begin
          instr_d = instr_in;
          case (instr_in.opcode)
            OP_NOP: ;
            OP_LOAD_W, OP_LOAD_A, OP_STORE: if (instr_in.len != '0) state_d = ST_MEM_REQ;
            OP_MATMUL: if (instr_in.len != '0) state_d = ST_CLEAR;
            OP_HALT:   state_d = ST_HALT;
            default:   illegal_d = 1'b1;
          endcase
        end
      end
      ST_MEM_REQ: begin
        cmd_valid = 1'b1;
        cmd_op    = to_mem_op(instr_q.opcode);
        cmd_addr  = instr_q.addr;
        cmd_len   = instr_q.len;
        if (bus.mem_cmd_ready) state_d = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        if (bus.mem_done) state_d = ST_IDLE;
      end
      ST_CLEAR: begin
        arr_clear  = 1'b1;
        timer_load = 1'b1;
        state_d    = ST_COMPUTE;
      end
      ST_COMPUTE: begin
        arr_en    = 1'b1;
        timer_dec = 1'b1;
        if (timer_last || !timer_active) state_d = ST_IDLE;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      instr_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.instr_ready   = instr_ready;
  assign bus.mem_cmd_valid = cmd_valid;
  assign bus.mem_cmd_op    = cmd_op;
  assign bus.mem_cmd_addr  = cmd_addr;
  assign bus.mem_cmd_len   = cmd_len;
  assign bus.array_clear   = arr_clear;
  assign bus.array_en      = arr_en;
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.halted        = (state_q == ST_HALT);
  assign bus.illegal_instr = illegal_q;

endmodule

// File: tb/tb_systolic_instr_scheduler.sv
// tb/tb_systolic_instr_scheduler.sv - self-checking bench for systolic_instr_scheduler
module tb_systolic_instr_scheduler;

  localparam int AS = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  systolic_instr_scheduler_if bus ();

  systolic_instr_scheduler #(.ARRAY_SIZE(AS), .CNT_W(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        valid;
    logic [63:0] data;
    logic        mready;
    logic        mdone;
    logic        e_ready;
    logic        e_cmd;
    logic        e_busy;
    logic        e_ill;
    logic [1:0]  e_op;
    logic [15:0] e_addr;
    logic [11:0] e_len;
  } vec_t;

  vec_t tbl[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int opc, input int addr, input int len);
    logic [63:0] w;
    w = '0;
    w[63:60] = opc[3:0];
    w[59:44] = addr[15:0];
    w[43:32] = len[11:0];
    w[31:0]  = $urandom;
    return w;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.instr_valid   = 1'b0;
    bus.instr_data    = '0;
    bus.mem_cmd_ready = 1'b0;
    bus.mem_done      = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".ready"}, bus.instr_ready, 1);
    check({tag, ".busy"}, bus.busy, 0);
    check({tag, ".cmd_valid"}, bus.mem_cmd_valid, 0);
    check({tag, ".array_en"}, bus.array_en, 0);
    check({tag, ".array_clear"}, bus.array_clear, 0);
  endtask

  // run a MATMUL already accepted in the current cycle; returns the array_en run length
  task automatic count_matmul(input int bound, output int en_cnt, output bit clr_ok);
    int clr_seen;
    en_cnt   = 0;
    clr_seen = 0;
    clr_ok   = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    #1;
    if (bus.array_clear === 1'b1 && bus.array_en === 1'b0) clr_seen = 1;
    for (int i = 0; i < bound; i++) begin
      tick();
      #1;
      if (bus.array_clear === 1'b1) clr_ok = 1'b0;
      if (bus.array_en === 1'b1) en_cnt++;
      else break;
    end
    if (clr_seen == 0) clr_ok = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // random-phase reference model state: transaction timestamps and pending-operation flags
  int cyc, free_at, clr_at, en_lo, en_hi, mem_dly;
  bit m_req, m_wait, m_ill, mem_out;
  logic [1:0]  m_op;
  logic [15:0] m_addr;
  logic [11:0] m_len;

  initial begin
    int en_cnt;
    bit clr_ok;
    logic [63:0] w;
    int opc, len;
    int opc_pool[10] = '{0, 1, 2, 3, 4, 3, 1, 5, 7, 14};

    idle_inputs();

    tbl[0]  = '{1'b1, mk(0, 0, 0), 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 12'd0};
    tbl[1]  = '{1'b1, mk(7, 16'h55, 3), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0, 12'd0};
    tbl[2]  = '{1'b1, mk(0, 0, 9), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0, 12'd0};
    tbl[3]  = '{1'b1, mk(2, 16'h40, 0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0, 12'd0};
    tbl[4]  = '{1'b1, mk(1, 16'h0100, 16), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0, 12'd0};
    tbl[5]  = '{1'b1, mk(4, 16'h0200, 5), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 16'h0100, 12'd16};
    tbl[6]  = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 16'h0100, 12'd16};
    tbl[7]  = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 16'h0100, 12'd16};
    tbl[8]  = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 16'h0100, 12'd16};
    tbl[9]  = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 16'h0, 12'd0};
    tbl[10] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 16'h0, 12'd0};
    tbl[11] = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0, 12'd0};

    // reset state
    do_reset();
    check_idle_outputs("reset");
    check("reset.halted", bus.halted, 0);
    check("reset.illegal", bus.illegal_instr, 0);
    check("reset.instr_reg_zero", (dut.instr_q == '0), 1);
    check("reset.counter", dut.u_timer.count_q, 0);

    // NOP / illegal / NOP back-to-back, LOAD_A len 0, then LOAD_W with delayed ready
    for (int i = 0; i < 12; i++) begin
      tick();
      bus.instr_valid   = tbl[i].valid;
      bus.instr_data    = tbl[i].data;
      bus.mem_cmd_ready = tbl[i].mready;
      bus.mem_done      = tbl[i].mdone;
      #1;
      check($sformatf("tbl%0d.ready", i), bus.instr_ready, tbl[i].e_ready);
      check($sformatf("tbl%0d.cmd_valid", i), bus.mem_cmd_valid, tbl[i].e_cmd);
      check($sformatf("tbl%0d.busy", i), bus.busy, tbl[i].e_busy);
      check($sformatf("tbl%0d.illegal", i), bus.illegal_instr, tbl[i].e_ill);
      check($sformatf("tbl%0d.array_en", i), bus.array_en, 0);
      check($sformatf("tbl%0d.array_clear", i), bus.array_clear, 0);
      if (tbl[i].e_cmd) begin
        check($sformatf("tbl%0d.op", i), bus.mem_cmd_op, tbl[i].e_op);
        check($sformatf("tbl%0d.addr", i), bus.mem_cmd_addr, tbl[i].e_addr);
        check($sformatf("tbl%0d.len", i), bus.mem_cmd_len, tbl[i].e_len);
      end
    end

    // MATMUL len 8: one clear then 8 + 2*8 - 2 = 22 enable cycles
    do_reset();
    tick();
    bus.instr_valid = 1'b1;
    bus.instr_data  = mk(3, 0, 8);
    #1;
    check("mm8.accept_ready", bus.instr_ready, 1);
    count_matmul(100, en_cnt, clr_ok);
    check("mm8.en_cycles", en_cnt, 22);
    check("mm8.clear_once", clr_ok, 1);
    check("mm8.ready_after", bus.instr_ready, 1);

    // HALT blocks a following STORE until reset
    do_reset();
    tick();
    bus.instr_valid = 1'b1;
    bus.instr_data  = mk(15, 0, 0);
    #1;
    check("halt.accept_ready", bus.instr_ready, 1);
    tick();
    bus.instr_data = mk(4, 16'h1234, 5);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("halt.halted", bus.halted, 1);
      check("halt.ready", bus.instr_ready, 0);
      check("halt.cmd_valid", bus.mem_cmd_valid, 0);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("halt.cleared", bus.halted, 0);
    check("halt.ready_after_rst", bus.instr_ready, 1);
    tick();
    bus.instr_valid = 1'b0;
    #1;
    check("halt.store_cmd_valid", bus.mem_cmd_valid, 1);
    check("halt.store_op", bus.mem_cmd_op, 2);
    check("halt.store_addr", bus.mem_cmd_addr, 16'h1234);
    check("halt.store_len", bus.mem_cmd_len, 5);

    // reset in the 5th COMPUTE cycle aborts the run
    do_reset();
    tick();
    bus.instr_valid = 1'b1;
    bus.instr_data  = mk(3, 0, 8);
    tick();
    bus.instr_valid = 1'b0;
    #1;
    check("abort.clear", bus.array_clear, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i == 4) rst = 1'b1;
      #1;
      check($sformatf("abort.en%0d", i), bus.array_en, 1);
    end
    tick();
    rst = 1'b0;
    #1;
    check_idle_outputs("abort");
    check("abort.counter", dut.u_timer.count_q, 0);
    tick();
    #1;
    check("abort.en_stays_low", bus.array_en, 0);

    // largest MATMUL: 4095 + 14 enable cycles
    do_reset();
    tick();
    bus.instr_valid = 1'b1;
    bus.instr_data  = mk(3, 0, 4095);
    count_matmul(5000, en_cnt, clr_ok);
    check("mm_max.en_cycles", en_cnt, 4095 + 2 * AS - 2);
    check("mm_max.clear_once", clr_ok, 1);

    // randomized traffic against the transaction-level model
    do_reset();
    cyc = 0; free_at = 0; clr_at = -1; en_lo = 0; en_hi = -1;
    m_req = 0; m_wait = 0; m_ill = 0; mem_out = 0; mem_dly = 0;
    m_op = '0; m_addr = '0; m_len = '0;
    for (int n = 0; n < 3000; n++) begin
      bit exp_ready;
      tick();
      opc = opc_pool[$urandom_range(0, 9)];
      if ($urandom_range(0, 5) == 0) len = 0;
      else if (opc == 3) len = $urandom_range(1, 30);
      else len = $urandom_range(1, 4095);
      bus.instr_valid   = ($urandom_range(0, 3) != 0);
      bus.instr_data    = mk(opc, $urandom_range(0, 65535), len);
      bus.mem_cmd_ready = ($urandom_range(0, 2) == 0);
      bus.mem_done      = 1'b0;
      if (mem_out) begin
        if (mem_dly == 0) begin
          bus.mem_done = 1'b1;
          mem_out      = 1'b0;
        end else begin
          mem_dly--;
        end
      end else if (!m_req && $urandom_range(0, 15) == 0) begin
        bus.mem_done = 1'b1;
      end
      #1;
      exp_ready = !m_req && !m_wait && (cyc >= free_at);
      check("rnd.ready", bus.instr_ready, exp_ready);
      check("rnd.busy", bus.busy, !exp_ready);
      check("rnd.cmd_valid", bus.mem_cmd_valid, m_req);
      check("rnd.illegal", bus.illegal_instr, m_ill);
      check("rnd.array_clear", bus.array_clear, (cyc == clr_at));
      check("rnd.array_en", bus.array_en, (cyc >= en_lo && cyc <= en_hi));
      check("rnd.halted", bus.halted, 0);
      if (m_req) begin
        check("rnd.op", bus.mem_cmd_op, m_op);
        check("rnd.addr", bus.mem_cmd_addr, m_addr);
        check("rnd.len", bus.mem_cmd_len, m_len);
      end
      w = bus.instr_data;
      if (exp_ready && bus.instr_valid) begin
        if (w[63:60] == 4'd1 || w[63:60] == 4'd2 || w[63:60] == 4'd4) begin
          if (w[43:32] != 0) begin
            m_req  = 1'b1;
            m_op   = (w[63:60] == 4'd1) ? 2'd0 : (w[63:60] == 4'd2) ? 2'd1 : 2'd2;
            m_addr = w[59:44];
            m_len  = w[43:32];
          end
        end else if (w[63:60] == 4'd3) begin
          if (w[43:32] != 0) begin
            clr_at  = cyc + 1;
            en_lo   = cyc + 2;
            en_hi   = cyc + 1 + int'(w[43:32]) + 2 * AS - 2;
            free_at = en_hi + 1;
          end
        end else if (w[63:60] != 4'd0) begin
          m_ill = 1'b1;
        end
      end else if (m_req && bus.mem_cmd_ready) begin
        m_req   = 1'b0;
        m_wait  = 1'b1;
        mem_out = 1'b1;
        mem_dly = $urandom_range(0, 3);
      end else if (m_wait && bus.mem_done) begin
        m_wait = 1'b0;
      end
      cyc++;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_instr_scheduler.md
# systolic_instr_scheduler

Sequencer between the instruction buffer and the systolic-array datapath.
- Pops 64-bit instructions from the buffer over a valid/ready handshake and decodes them one at a time.
- Sequences memory load/store commands and timed array compute runs, with one operation in flight.
- Sits directly downstream of the instruction buffer, in the same `clk` domain as the controller.

## Interface
Parameters:
- `ARRAY_SIZE`, 8: PE rows/cols of the square array; legal range 2..2048.
- `CNT_W`, 14: width of the compute cycle counter.

Ports:
- `clk` in 1: single clock; one clock only.
- `rst` in 1: reset, synchronous and active-high.
- `instr_valid` in 1: buffer holds an instruction.
- `instr_data` in 64: instruction word.
- `instr_ready` out 1: scheduler accepts `instr_data` this cycle.
- `mem_cmd_valid` out 1: memory command pending.
- `mem_cmd_op` out 2: 0 LOAD_W, 1 LOAD_A, 2 STORE.
- `mem_cmd_addr` out 16: start address.
- `mem_cmd_len` out 12: number of words.
- `mem_cmd_ready` in 1: memory accepts the command.
- `mem_done` in 1: single-cycle pulse when the accepted command completes.
- `array_clear` out 1: single-cycle pulse that zeroes the accumulators.
- `array_en` out 1: array advances one step per cycle while high.
- `busy` out 1: state is not IDLE.
- `halted` out 1: HALT executed; sticky until `rst`.
- `illegal_instr` out 1: an undefined opcode was seen; sticky until `rst`.

## Operation
Instruction fields:
- `[63:60]` opcode; `[59:44]` addr; `[43:32]` len; `[31:0]` reserved, ignored.
- Opcodes: 0 NOP, 1 LOAD_W, 2 LOAD_A, 3 MATMUL, 4 STORE, 15 HALT. All other values are illegal.

FSM states: IDLE, MEM_REQ, MEM_WAIT, CLEAR, COMPUTE, HALT.
- IDLE: `instr_ready`=1. When `instr_valid&&instr_ready`, latch the word and branch on opcode:
  - NOP, or len==0 on any data op: stay in IDLE.
  - Illegal opcode: set `illegal_instr`, stay in IDLE; the instruction is consumed.
  - LOAD_W, LOAD_A, STORE: go to MEM_REQ.
  - MATMUL: go to CLEAR.
  - HALT: go to HALT.
- MEM_REQ: drive `mem_cmd_valid`=1 with op/addr/len held stable until `mem_cmd_ready`, then go to MEM_WAIT.
- MEM_WAIT: wait for `mem_done`, then go to IDLE.
  - A `mem_done` pulse arriving in any other state is ignored.
- CLEAR: assert `array_clear` for one cycle, load the counter with len+2*ARRAY_SIZE−2, go to COMPUTE.
- COMPUTE: `array_en`=1 each cycle, decrement the counter. The cycle the counter reads 1 is the last `array_en` cycle; go to IDLE next.
- HALT: `instr_ready`=0 and `halted`=1 permanently; only `rst` exits this state.

Counter arithmetic: zero-extend len to `CNT_W`, then add 2*ARRAY_SIZE−2. Maximum value 4095+4094 fits in 14 bits.

## Timing
- Reset values, one cycle after `rst` sampled high: state IDLE, counter 0.
  - All outputs 0 except `instr_ready`=1.
  - `halted` and `illegal_instr` cleared.
  - Latched instruction register cleared to 0.
- `rst` mid-operation (any state) aborts immediately. No `mem_cmd_valid` or `array_en` in the cycle after.
- Issue latency: accept in cycle N, then one of:
  - `mem_cmd_valid` first high in N+1.
  - `array_clear` high in N+1, `array_en` high from N+2 through N+1+len+2*ARRAY_SIZE−2.
- Earliest next accept:
  - After a memory op: the cycle after `mem_done`.
  - After MATMUL: the cycle after the last `array_en`.
  - NOP or illegal: back-to-back, one instruction per cycle.
- `mem_done` coincident with `mem_cmd_ready` (zero-latency memory) in MEM_REQ is not legal. The memory asserts done at least one cycle after accept.
- `instr_ready` is a registered-state decode: it does not depend combinationally on `instr_valid`.
- `array_clear` and `array_en` are never high in the same cycle.

## Structure
- Shared package `systolic_pkg`:
  - opcode enum `opcode_e` (4-bit).
  - `mem_op_e` (2-bit).
  - state enum `sched_state_e`.
  - field-position constants for `[63:60]`, `[59:44]`, `[43:32]`.
  - struct `instr_t` unpacking the 64-bit word.
- One sub-module, `compute_timer`: load value, decrement enable, outputs `active` and `last`, `CNT_W`-bit. Everything else lives in the top FSM.

## Test plan
- Reset then LOAD_W addr=0x0100 len=16; `mem_cmd_ready` held low 3 cycles. Expect `mem_cmd_valid` held for 4 cycles with op=0, addr=0x0100, len=16 stable; `instr_ready`=0 until the cycle after `mem_done`.
- MATMUL len=8, ARRAY_SIZE=8. Expect `array_clear` in 1 cycle, then exactly 22 consecutive `array_en` cycles, then `instr_ready`=1.
- Back-to-back NOP, opcode 7, NOP with `instr_valid` constant. Expect 3 accepts in 3 cycles, `illegal_instr`=1 from the cycle after opcode 7, no memory or array activity.
- LOAD_A with len=0. Expect consumed in 1 cycle, no `mem_cmd_valid`.
- HALT followed by a valid STORE. Expect `halted`=1 and the STORE never accepted; after a 1-cycle `rst`, `halted`=0 and the STORE is accepted next cycle.
- `rst` asserted in the 5th cycle of COMPUTE. Expect `array_en`=0 the following cycle, state IDLE, counter 0.
